// File: rtl/ipu_capture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ipu_capture_ctrl : capture sequencing, finger-detect confirm, watchdog  |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
module ipu_capture_ctrl #(
  parameter int unsigned SETTLE_FRAMES  = 4,
  parameter int unsigned CONFIRM_FRAMES = 3,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iCFG_DONE,
  input  logic       iEN,
  input  logic       iFVAL,
  input  logic       iDET,
  input  logic [3:0] iLOC,
  input  logic       iACK,
  output logic       oSTART,
  output logic       oEND,
  output logic       oCAPTURING,
  output logic       oINT,
  output logic [3:0] oLOC,
  output logic       oERR,
  output logic [2:0] oSTATE
);

  localparam int SW = (SETTLE_FRAMES  > 0) ? $clog2(SETTLE_FRAMES + 1)  : 1;
  localparam int CW = (CONFIRM_FRAMES > 0) ? $clog2(CONFIRM_FRAMES + 1) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_FRAMES);
  localparam logic [CW-1:0] CONF_MAX   = CW'(CONFIRM_FRAMES);
  localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT_CYCLES);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
  localparam logic [2:0] FAULT  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic          fval_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] conf_q, conf_d;
  logic [3:0]    cand_q, cand_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          start_q, start_d, end_q, end_d, cap_q, cap_d;
  logic          int_q, int_d, err_q, err_d;
  logic [3:0]    loc_q, loc_d;

  logic          w_frame_end, w_valid, w_timeout;
  logic [SW-1:0] w_settle_inc;
  logic [CW-1:0] w_conf_inc;
  logic [WW-1:0] w_wd_inc;

  assign w_frame_end  = fval_q & ~iFVAL;
  assign w_valid      = iDET && (iLOC <= 4'd8);
  assign w_settle_inc = (settle_q >= SETTLE_MAX) ? settle_q : settle_q + 1'b1;
  assign w_conf_inc   = (conf_q   >= CONF_MAX)   ? conf_q   : conf_q + 1'b1;
  assign w_wd_inc     = (wdog_q   >= WD_MAX)     ? wdog_q   : wdog_q + 1'b1;
  // A frame end in the same cycle restarts the window, so it never times out.
  assign w_timeout    = !w_frame_end && (w_wd_inc >= WD_MAX);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      fval_q   <= 1'b0;
      settle_q <= '0;
      conf_q   <= '0;
      cand_q   <= '0;
      wdog_q   <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      cap_q    <= 1'b0;
      int_q    <= 1'b0;
      err_q    <= 1'b0;
      loc_q    <= '0;
    end else begin
      state_q  <= state_d;
      fval_q   <= iFVAL;
      settle_q <= settle_d;
      conf_q   <= conf_d;
      cand_q   <= cand_d;
      wdog_q   <= wdog_d;
      start_q  <= start_d;
      end_q    <= end_d;
      cap_q    <= cap_d;
      int_q    <= int_d;
      err_q    <= err_d;
      loc_q    <= loc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    conf_d   = conf_q;
    cand_d   = cand_q;
    wdog_d   = wdog_q;
    case (state_q)
      IDLE: begin
        if (iEN && iCFG_DONE) state_d = START;
      end
      START: begin
        state_d  = SETTLE;
        settle_d = '0;
        conf_d   = '0;
        wdog_d   = '0;
      end
      SETTLE, RUN, HOLD: begin
        wdog_d = w_frame_end ? '0 : w_wd_inc;
        if (!iEN) begin
          state_d = STOP;
        end else if (w_timeout) begin
          state_d = FAULT;
        end else if (state_q == HOLD) begin
          if (iACK) begin
            state_d = RUN;
            conf_d  = '0;
          end
        end else if (state_q == SETTLE) begin
          if (w_frame_end) begin
            settle_d = w_settle_inc;
            if (w_settle_inc >= SETTLE_MAX) begin
              state_d = RUN;
              conf_d  = '0;
            end
          end
        end else if (w_frame_end) begin
          if (w_valid && (iLOC == cand_q)) begin
            conf_d = w_conf_inc;
          end else if (w_valid) begin
            cand_d = iLOC;
            conf_d = CW'(1);
          end else begin
            conf_d = '0;
          end
          if (w_valid && (conf_d >= CONF_MAX)) state_d = HOLD;
        end
      end
      STOP: begin
        state_d = IDLE;
      end
      FAULT: begin
        if (!iEN) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with oSTATE.
  always_comb begin
    start_d = (state_d == START);
    end_d   = (state_d == STOP) || ((state_d == FAULT) && (state_q != FAULT));
    cap_d   = (state_d == SETTLE) || (state_d == RUN) || (state_d == HOLD);
    int_d   = (state_d == HOLD);
    err_d   = (state_d == FAULT);
    loc_d   = ((state_d == HOLD) && (state_q != HOLD)) ? cand_d : loc_q;
  end

  assign oSTART     = start_q;
  assign oEND       = end_q;
  assign oCAPTURING = cap_q;
  assign oINT       = int_q;
  assign oLOC       = loc_q;
  assign oERR       = err_q;
  assign oSTATE     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ipu_capture_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_ipu_capture_ctrl : scoreboard bench for ipu_capture_ctrl              |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ipu_capture_ctrl;

  localparam int TMO = 100;

  logic       iCLK = 1'b0;
  logic       iRST_N, iCFG_DONE, iEN, iFVAL, iDET, iACK;
  logic [3:0] iLOC;
  logic       oSTART, oEND, oCAPTURING, oINT, oERR;
  logic [3:0] oLOC;
  logic [2:0] oSTATE;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_end    = 0;
  logic int_prev = 1'b0;

  logic [3:0] exp_q[$];
  logic [3:0] m_cand;
  int         m_cnt;
  int         m_phase;   // 0 = not in RUN, 1 = RUN, 2 = HOLD

  always #5 iCLK = ~iCLK;

  ipu_capture_ctrl #(
    .SETTLE_FRAMES (4),
    .CONFIRM_FRAMES(3),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iCFG_DONE (iCFG_DONE),
    .iEN       (iEN),
    .iFVAL     (iFVAL),
    .iDET      (iDET),
    .iLOC      (iLOC),
    .iACK      (iACK),
    .oSTART    (oSTART),
    .oEND      (oEND),
    .oCAPTURING(oCAPTURING),
    .oINT      (oINT),
    .oLOC      (oLOC),
    .oERR      (oERR),
    .oSTATE    (oSTATE)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_state"}, 32'(oSTATE), 32'd0);
    check_val({tag, "_start"}, 32'(oSTART), 32'd0);
    check_val({tag, "_end"},   32'(oEND),   32'd0);
    check_val({tag, "_cap"},   32'(oCAPTURING), 32'd0);
    check_val({tag, "_int"},   32'(oINT),   32'd0);
    check_val({tag, "_loc"},   32'(oLOC),   32'd0);
    check_val({tag, "_err"},   32'(oERR),   32'd0);
  endtask

  // Monitor: interrupt rising edges pop the scoreboard; pulse counters.
  always @(negedge iCLK) begin
    if (oSTART) n_start++;
    if (oEND)   n_end++;
    if (oINT && !int_prev) begin
      check_val("int_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_val("int_loc", 32'(oLOC), 32'(exp_q.pop_front()));
    end
    int_prev = oINT;
  end

  task automatic drive_frame(input logic det, input logic [3:0] loc);
    iFVAL = 1'b0;
    repeat (2) step();
    iFVAL = 1'b1;
    repeat (8) step();
    iFVAL = 1'b0;
    iDET  = det;
    iLOC  = loc;
    step();
    iDET  = 1'b0;
    iLOC  = 4'd0;
  endtask

  task automatic run_frame(input logic det, input logic [3:0] loc, input string tag);
    if (m_phase == 1) begin
      if (det && (loc <= 4'd8)) begin
        if (loc == m_cand) m_cnt++;
        else begin
          m_cand = loc;
          m_cnt  = 1;
        end
      end else begin
        m_cnt = 0;
      end
      if (m_cnt >= 3) begin
        exp_q.push_back(loc);
        m_phase = 2;
      end
    end
    drive_frame(det, loc);
    check_val(tag, 32'(oINT), 32'(m_phase == 2));
  endtask

  task automatic start_capture();
    step();
    check_val("start_state", 32'(oSTATE), 32'd1);
    check_val("start_pulse", 32'(oSTART), 32'd1);
    step();
    check_val("settle_state", 32'(oSTATE), 32'd2);
    check_val("settle_cap", 32'(oCAPTURING), 32'd1);
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) drive_frame(1'b0, 4'd0);
    check_val("settle_3rd", 32'(oSTATE), 32'd2);
    drive_frame(1'b0, 4'd0);
    check_val("run_after_4th", 32'(oSTATE), 32'd3);
    check_val("run_int", 32'(oINT), 32'd0);
    m_phase = 1;
    m_cnt   = 0;
  endtask

  task automatic do_ack(input string tag);
    iACK = 1'b1;
    step();
    iACK = 1'b0;
    m_phase = 1;
    m_cnt   = 0;
    check_val({tag, "_int"},   32'(oINT),   32'd0);
    check_val({tag, "_state"}, 32'(oSTATE), 32'd3);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic       seq_det[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] seq_loc[9] = '{4'd2, 4'd2, 4'd7, 4'd7, 4'd3, 4'd9, 4'd7, 4'd7, 4'd7};
    int ends_before;
    int cyc;

    iRST_N = 1'b0; iCFG_DONE = 1'b0; iEN = 1'b0; iFVAL = 1'b0;
    iDET = 1'b0; iLOC = 4'd0; iACK = 1'b0;
    m_cand = 4'd0; m_cnt = 0; m_phase = 0;
    repeat (3) step();
    check_zero("rst");
    iRST_N = 1'b1;
    step();

    // Enable without configuration complete must not start.
    iEN = 1'b1;
    repeat (3) step();
    check_val("idle_cfg_gate", 32'(oSTATE), 32'd0);

    iCFG_DONE = 1'b1;
    start_capture();
    settle();
    check_val("start_count", 32'(n_start), 32'd1);

    // Three matching detections raise the interrupt.
    for (int i = 0; i < 3; i++) run_frame(1'b1, 4'd5, "conf5");
    check_val("hold_state", 32'(oSTATE), 32'd4);
    check_val("hold_loc", 32'(oLOC), 32'd5);
    run_frame(1'b1, 4'd2, "hold_frame");
    check_val("hold_loc_stable", 32'(oLOC), 32'd5);
    do_ack("ack5");

    // Acknowledge outside HOLD leaves the confirm count alone.
    run_frame(1'b1, 4'd3, "pre_ack_a");
    run_frame(1'b1, 4'd3, "pre_ack_b");
    iACK = 1'b1;
    step();
    iACK = 1'b0;
    check_val("ack_in_run_state", 32'(oSTATE), 32'd3);
    run_frame(1'b1, 4'd3, "ack_ignored_int");
    do_ack("ack3");

    // Candidate switching, no-detect and out-of-range grid.
    for (int i = 0; i < 9; i++) run_frame(seq_det[i], seq_loc[i], "seq");
    check_val("seq_loc", 32'(oLOC), 32'd7);
    do_ack("ack7");

    // Asynchronous reset mid-RUN with count 2.
    run_frame(1'b1, 4'd4, "prerst_a");
    run_frame(1'b1, 4'd4, "prerst_b");
    ends_before = n_end;
    @(posedge iCLK);
    #3 iRST_N = 1'b0;
    #1;
    check_zero("async_rst");
    m_cand = 4'd0; m_cnt = 0; m_phase = 0;
    step();
    check_val("rst_no_end", 32'(n_end), 32'(ends_before));
    #2 iRST_N = 1'b1;
    start_capture();
    settle();
    check_val("restart_count", 32'(n_start), 32'd2);
    run_frame(1'b1, 4'd4, "postrst_a");
    run_frame(1'b1, 4'd4, "postrst_b");
    run_frame(1'b1, 4'd4, "postrst_c");

    // In HOLD: iEN drop, iACK and watchdog expiry all in the same cycle.
    repeat (TMO - 1) step();
    iEN  = 1'b0;
    iACK = 1'b1;
    step();
    iACK = 1'b0;
    check_val("stop_state", 32'(oSTATE), 32'd5);
    check_val("stop_end", 32'(oEND), 32'd1);
    check_val("stop_err", 32'(oERR), 32'd0);
    check_val("stop_int", 32'(oINT), 32'd0);
    step();
    check_val("stop_to_idle", 32'(oSTATE), 32'd0);
    check_val("stop_end_once", 32'(oEND), 32'd0);
    m_phase = 0;

    // Watchdog: configuration drop during capture is ignored.
    iEN = 1'b1;
    start_capture();
    iCFG_DONE = 1'b0;
    settle();
    iFVAL = 1'b1;
    repeat (TMO / 2) step();
    check_val("wd_early_err", 32'(oERR), 32'd0);
    check_val("wd_early_state", 32'(oSTATE), 32'd3);
    ends_before = n_end;
    cyc = 0;
    while (!oERR && cyc < 4 * TMO) begin
      step();
      cyc++;
    end
    check_val("fault_err", 32'(oERR), 32'd1);
    check_val("fault_state", 32'(oSTATE), 32'd6);
    check_val("fault_end", 32'(oEND), 32'd1);
    check_val("fault_cap", 32'(oCAPTURING), 32'd0);
    check_val("fault_int", 32'(oINT), 32'd0);
    repeat (5) step();
    check_val("fault_sticky", 32'(oSTATE), 32'd6);
    check_val("fault_end_once", 32'(n_end), 32'(ends_before + 1));
    iEN = 1'b0;
    step();
    check_val("fault_exit_state", 32'(oSTATE), 32'd0);
    check_val("fault_exit_err", 32'(oERR), 32'd0);
    iFVAL = 1'b0;

    // Configuration still low: enable alone must not restart.
    iEN = 1'b1;
    repeat (3) step();
    check_val("idle_cfg_low", 32'(oSTATE), 32'd0);

    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
